// File: rtl/branch_scheduler_pkg.sv
// Shared types for the branch reservation station: datapath width, branch op
// encodings and the packed reservation-entry record.
package branch_scheduler_pkg;

    localparam int XLEN     = 32;
    localparam int BR_TAG_W = 5;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_BEQ  = 4'd1,
        FN_BNE  = 4'd2,
        FN_BLT  = 4'd3,
        FN_BGE  = 4'd4,
        FN_BLTU = 4'd5,
        FN_BGEU = 4'd6,
        FN_JAL  = 4'd7,
        FN_JALR = 4'd8
    } ALU_FUNC;

    typedef struct packed {
        logic                valid;
        ALU_FUNC             func;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     rs1_val;
        logic [BR_TAG_W-1:0] rs1_tag;
        logic [XLEN-1:0]     rs2_val;
        logic [BR_TAG_W-1:0] rs2_tag;
        logic                pred_taken;
        logic [XLEN-1:0]     pred_target;
        logic [BR_TAG_W-1:0] rob_tag;
    } BR_ENTRY;

    function automatic logic [XLEN-1:0] link_addr(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/branch_unit.sv
// Combinational branch evaluator: direction condition and taken target.
// JALR target is rs1+imm without clearing bit 0.
module branch_unit
    import branch_scheduler_pkg::*;
(
    input  ALU_FUNC         func,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond,
    output logic [XLEN-1:0] target
);

    always_comb begin
        cond   = 1'b0;
        target = pc + imm;
        case (func)
            FN_BEQ:  cond = (rs1 == rs2);
            FN_BNE:  cond = (rs1 != rs2);
            FN_BLT:  cond = ($signed(rs1) < $signed(rs2));
            FN_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            FN_BLTU: cond = (rs1 < rs2);
            FN_BGEU: cond = (rs1 >= rs2);
            FN_JAL:  cond = 1'b1;
            FN_JALR: begin
                cond   = 1'b1;
                target = rs1 + imm;
            end
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_scheduler.sv
// Branch reservation station: collapsing age-ordered queue with CDB wakeup,
// oldest-ready issue into branch_unit, and a registered valid/ready result.
module branch_scheduler
    import branch_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = BR_TAG_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  ALU_FUNC          in_func,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic [XLEN-1:0]  in_rs2_val,
    input  logic [TAG_W-1:0] in_rs1_tag,
    input  logic [TAG_W-1:0] in_rs2_tag,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    input  logic [TAG_W-1:0] in_rob_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_value,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_rob_tag,
    output logic             res_taken,
    output logic [XLEN-1:0]  res_next_pc,
    output logic [XLEN-1:0]  res_link,
    output logic             res_mispredict
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    BR_ENTRY          q      [DEPTH];
    BR_ENTRY          q_nxt  [DEPTH];
    BR_ENTRY          woken  [DEPTH+1];
    BR_ENTRY          new_entry;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] alloc_pos;
    logic [IDX_W-1:0] sel;
    logic [DEPTH-1:0] at_or_above;
    logic             any_ready;
    logic             issue;
    logic             alloc;
    logic             bu_cond;
    logic [XLEN-1:0]  bu_target;
    logic [XLEN-1:0]  bu_link;
    logic [XLEN-1:0]  bu_next_pc;

    function automatic BR_ENTRY wake(input BR_ENTRY e, input logic cv,
                                     input logic [TAG_W-1:0] ct, input logic [XLEN-1:0] cval);
        BR_ENTRY w;
        w = e;
        if (cv && e.rs1_tag != '0 && e.rs1_tag == ct) begin
            w.rs1_val = cval;
            w.rs1_tag = '0;
        end
        if (cv && e.rs2_tag != '0 && e.rs2_tag == ct) begin
            w.rs2_val = cval;
            w.rs2_tag = '0;
        end
        return w;
    endfunction

    // Conservative: a full queue refuses dispatch even when an issue frees a slot.
    assign in_ready = (count < CNT_W'(DEPTH));
    assign alloc    = in_valid & in_ready;

    always_comb begin
        any_ready   = 1'b0;
        sel         = '0;
        at_or_above = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!any_ready && q[i].valid && q[i].rs1_tag == '0 && q[i].rs2_tag == '0) begin
                any_ready = 1'b1;
                sel       = IDX_W'(i);
            end
            at_or_above[i] = any_ready;
        end
    end

    assign issue = any_ready & (~res_valid | res_ready);

    always_comb begin
        new_entry = '{valid:       1'b1,
                      func:        in_func,
                      pc:          in_pc,
                      imm:         in_imm,
                      rs1_val:     in_rs1_val,
                      rs1_tag:     in_rs1_tag,
                      rs2_val:     in_rs2_val,
                      rs2_tag:     in_rs2_tag,
                      pred_taken:  in_pred_taken,
                      pred_target: in_pred_target,
                      rob_tag:     in_rob_tag};
        new_entry = wake(new_entry, cdb_valid, cdb_tag, cdb_value);
    end

    // Wakeup first, then collapse over the issued slot, then drop the new op
    // at the first free slot left after the collapse.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = wake(q[i], cdb_valid, cdb_tag, cdb_value);
        end
        woken[DEPTH] = '0;
        alloc_pos    = issue ? count - CNT_W'(1) : count;
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = (issue && at_or_above[i]) ? woken[i+1] : woken[i];
            if (alloc && alloc_pos == CNT_W'(i)) begin
                q_nxt[i] = new_entry;
            end
        end
        count_nxt = count + CNT_W'(alloc) - CNT_W'(issue);
    end

    branch_unit u_branch_unit (
        .func   (q[sel].func),
        .pc     (q[sel].pc),
        .imm    (q[sel].imm),
        .rs1    (q[sel].rs1_val),
        .rs2    (q[sel].rs2_val),
        .cond   (bu_cond),
        .target (bu_target)
    );

    assign bu_link    = link_addr(q[sel].pc);
    assign bu_next_pc = bu_cond ? bu_target : bu_link;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_valid      <= 1'b0;
            res_rob_tag    <= '0;
            res_taken      <= 1'b0;
            res_next_pc    <= '0;
            res_link       <= '0;
            res_mispredict <= 1'b0;
        end else if (flush) begin
            res_valid <= 1'b0;
        end else if (issue) begin
            res_valid      <= 1'b1;
            res_rob_tag    <= q[sel].rob_tag;
            res_taken      <= bu_cond;
            res_next_pc    <= bu_next_pc;
            res_link       <= bu_link;
            res_mispredict <= (bu_cond != q[sel].pred_taken) |
                              (bu_cond & (bu_target != q[sel].pred_target));
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
